glitch_filter_scheduler: RTL and testbench
==========================================

GLITCH_FILTER_SCHEDULER -- requirements
Module: glitch_filter_scheduler

Interface
REQ-001 SHALL have parameter CHANNELS, default 8; number of filtered input channels, range 2..64.
REQ-002 SHALL have parameter CNT_W, default 8; width of the filter-length setting and the per-channel counters.
REQ-003 SHALL have parameter DEFAULT_LEN, default 4; the filter length loaded at reset.
REQ-004 SHALL have ports:
- clk  input  1  sole clock, rising edge
- rstN  input  1  asynchronous, active-low reset
- enable  input  1  scan enable
- inData  input  CHANNELS  raw channel inputs
- outData  output  CHANNELS  filtered levels
- cfgValid  input  1  config offer
- cfgReady  output  1  config accept
- cfgLen  input  CNT_W  new filter length, in visits
- eventValid  output  1  one-cycle commit pulse
- eventChan  output  clog2(CHANNELS)  channel that committed
- eventLevel  output  1  new level of that channel

Function
REQ-005 SHALL register inData once per cycle; all decisions use the registered copy (1-cycle input latency).
REQ-006 SHALL share one evaluation engine round-robin: index 0..CHANNELS-1, one channel visited per SCAN cycle, wrapping CHANNELS-1 -> 0.
REQ-007 At each visit, the sample matching outData[i] SHALL clear cnt[i] to 0.
REQ-008 At each visit, a mismatch with cnt[i]+1 >= effLen SHALL set outData[i] to the sample, clear cnt[i], and pulse eventValid for one cycle with eventChan=i and eventLevel=new value.
REQ-009 At each visit, a mismatch with cnt[i]+1 < effLen SHALL increment cnt[i]; the counter SHALL saturate at all-ones.
REQ-010 effLen SHALL equal filtLen, except filtLen=0 SHALL be treated as 1.
REQ-011 A transition SHALL commit only after effLen consecutive mismatching visits; any matching visit restarts the count.
REQ-012 At most one event SHALL occur per cycle; eventChan and eventLevel are don't-care while eventValid=0.
REQ-013 SHALL implement the states IDLE, SCAN and RELOAD.
- IDLE: no visits, outData held.
- IDLE -> SCAN when enable=1, starting at index 0.
- SCAN -> IDLE in the cycle after enable=0 is seen; the visit in the current cycle completes; all cnt cleared; index reset to 0.
- SCAN -> RELOAD at a wrap (visit of CHANNELS-1) when pendValid=1.
- RELOAD lasts one cycle: filtLen<=pendLen, all cnt cleared, pendValid<=0; then SCAN at index 0, or IDLE if enable=0.
REQ-014 Config handshake: a transfer occurs when cfgValid&&cfgReady; cfgReady=!pendValid.
- In SCAN, a transfer latches pendLen and sets pendValid.
- A transfer in the same cycle as the CHANNELS-1 visit SHALL apply at the following wrap, not the current one.
REQ-015 In IDLE, a transfer SHALL write filtLen directly on the next edge; pendValid stays 0.
REQ-016 No visit occurs in RELOAD; the sweep after RELOAD restarts at channel 0.

Reset
REQ-017 While rstN=0, the block SHALL hold: outData=0, all cnt=0, index=0, state=IDLE, filtLen=DEFAULT_LEN, pendValid=0, eventValid=0, input register=0.
REQ-018 After reset, cfgReady SHALL read 1.
REQ-019 Reset asserted mid-sweep or mid-RELOAD SHALL abandon all pending state immediately; no event SHALL be emitted.

Structure
REQ-020 Package glitch_filter_pkg SHALL hold the state enum (IDLE/SCAN/RELOAD) and the default CHANNELS/CNT_W/DEFAULT_LEN constants.
REQ-021 Per-visit decision logic SHALL be sub-module glitch_filter_eval (combinational; inputs sample, level, cnt, effLen; outputs next cnt, next level, commit).
REQ-022 Per-channel state SHALL be flop arrays, not RAM.

Verification (CHANNELS=4, DEFAULT_LEN=3)
REQ-023 Reset: pulse rstN low mid-run -> outData=0000, cfgReady=1, eventValid=0 on the same cycle.
REQ-024 Step: enable=1, inData[2] held 1 -> exactly one eventValid (eventChan=2, eventLevel=1) on the 3rd visit of channel 2; no further events.
REQ-025 Glitch: inData[1] high for 2 visits, then low -> no event; outData[1] stays 0.
REQ-026 Reconfig in SCAN: cfgLen=1 accepted mid-sweep -> cfgReady=0 until wrap, one RELOAD cycle, then cfgReady=1; next single-visit mismatch commits immediately.
REQ-027 Enable drop: deassert enable with cnt[3]=2 -> IDLE; outData unchanged; after re-enable, channel 3 needs 3 fresh mismatching visits to commit.
REQ-028 Zero length: cfgLen=0 accepted in IDLE -> behaves as 1; every mismatch commits on its first visit.

Source files
------------

// File: rtl/glitch_filter_pkg.sv
// Shared definitions for the glitch filter scheduler.
//   gfState_e     : scheduler FSM states (idle, scanning, reloading filter length)
//   DefChannels   : default number of filtered channels
//   DefCntW       : default width of the filter length and per-channel counters
//   DefDefaultLen : default filter length loaded at reset, in visits
package glitch_filter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StReload
    } gfState_e;

    localparam int unsigned DefChannels   = 8;
    localparam int unsigned DefCntW       = 8;
    localparam int unsigned DefDefaultLen = 4;

endpackage

// File: rtl/glitch_filter_eval.sv
// Per-visit decision for one channel (purely combinational).
//   sample    : registered raw input of the visited channel
//   level     : current filtered level of that channel
//   cnt       : consecutive mismatching visits seen so far
//   effLen    : effective filter length (never 0)
//   cntNext   : counter value to write back
//   levelNext : filtered level to write back
//   commit    : the level changes on this visit
module glitch_filter_eval #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             sample,
    input  logic             level,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] effLen,
    output logic [CNT_W-1:0] cntNext,
    output logic             levelNext,
    output logic             commit
);

    // One bit wider so cnt+1 cannot wrap before the length compare.
    logic [CNT_W:0] cntInc;
    assign cntInc = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        cntNext   = cnt;
        levelNext = level;
        commit    = 1'b0;
        if (sample == level) begin
            cntNext = '0;
        end else if (cntInc >= {1'b0, effLen}) begin
            commit    = 1'b1;
            levelNext = sample;
            cntNext   = '0;
        end else if (cnt != '1) begin
            cntNext = cntInc[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/glitch_filter_scheduler.sv
// Round-robin glitch filter: one shared evaluation engine visits one channel per
// scan cycle and commits a level change only after effLen consecutive mismatches.
//   clk, rstN  : clock (rising edge), asynchronous active-low reset
//   enable     : scan enable
//   inData     : raw channel inputs (registered before use)
//   outData    : filtered levels
//   cfgValid/cfgReady/cfgLen : filter-length update handshake
//   eventValid/eventChan/eventLevel : one-cycle pulse per committed change
module glitch_filter_scheduler
    import glitch_filter_pkg::*;
#(
    parameter int unsigned CHANNELS    = DefChannels,
    parameter int unsigned CNT_W       = DefCntW,
    parameter int unsigned DEFAULT_LEN = DefDefaultLen
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic                        enable,
    input  logic [CHANNELS-1:0]         inData,
    output logic [CHANNELS-1:0]         outData,
    input  logic                        cfgValid,
    output logic                        cfgReady,
    input  logic [CNT_W-1:0]            cfgLen,
    output logic                        eventValid,
    output logic [$clog2(CHANNELS)-1:0] eventChan,
    output logic                        eventLevel
);

    localparam int unsigned IdxW = $clog2(CHANNELS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(CHANNELS - 1);

    gfState_e          stateQ, stateD;
    logic [IdxW-1:0]   idxQ, idxD;
    logic [CNT_W-1:0]  cntQ [CHANNELS];
    logic [CNT_W-1:0]  cntD [CHANNELS];
    logic [CHANNELS-1:0] outQ, outD;
    logic [CHANNELS-1:0] inQ;
    logic [CNT_W-1:0]  filtLenQ, filtLenD;
    logic [CNT_W-1:0]  pendLenQ, pendLenD;
    logic              pendValidQ, pendValidD;
    logic              evValidQ, evValidD;
    logic [IdxW-1:0]   evChanQ, evChanD;
    logic              evLevelQ, evLevelD;

    logic [CNT_W-1:0]  effLen;
    logic [CNT_W-1:0]  evalCnt;
    logic              evalLevel;
    logic              evalCommit;
    logic              cfgXfer;

    assign effLen   = (filtLenQ == '0) ? CNT_W'(1) : filtLenQ;
    assign cfgReady = !pendValidQ;
    assign cfgXfer  = cfgValid && cfgReady;

    glitch_filter_eval #(
        .CNT_W(CNT_W)
    ) uEval (
        .sample   (inQ[idxQ]),
        .level    (outQ[idxQ]),
        .cnt      (cntQ[idxQ]),
        .effLen   (effLen),
        .cntNext  (evalCnt),
        .levelNext(evalLevel),
        .commit   (evalCommit)
    );

    always_comb begin
        stateD     = stateQ;
        idxD       = idxQ;
        cntD       = cntQ;
        outD       = outQ;
        filtLenD   = filtLenQ;
        pendLenD   = pendLenQ;
        pendValidD = pendValidQ;
        evValidD   = 1'b0;
        evChanD    = idxQ;
        evLevelD   = evalLevel;

        unique case (stateQ)
            StIdle: begin
                // Outside a sweep the new length can take effect immediately.
                if (cfgXfer) begin
                    filtLenD = cfgLen;
                end
                if (enable) begin
                    stateD = StScan;
                    idxD   = '0;
                end
            end
            StScan: begin
                cntD[idxQ] = evalCnt;
                outD[idxQ] = evalLevel;
                evValidD   = evalCommit;
                if (cfgXfer) begin
                    pendLenD   = cfgLen;
                    pendValidD = 1'b1;
                end
                if (!enable) begin
                    stateD = StIdle;
                    idxD   = '0;
                    for (int c = 0; c < CHANNELS; c++) begin
                        cntD[c] = '0;
                    end
                end else if (idxQ == LastIdx) begin
                    idxD = '0;
                    // Registered pendValid: a transfer on this visit waits a full sweep.
                    if (pendValidQ) begin
                        stateD = StReload;
                    end
                end else begin
                    idxD = idxQ + IdxW'(1);
                end
            end
            StReload: begin
                filtLenD   = pendLenQ;
                pendValidD = 1'b0;
                idxD       = '0;
                for (int c = 0; c < CHANNELS; c++) begin
                    cntD[c] = '0;
                end
                stateD = enable ? StScan : StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stateQ     <= StIdle;
            idxQ       <= '0;
            cntQ       <= '{default: '0};
            outQ       <= '0;
            inQ        <= '0;
            filtLenQ   <= CNT_W'(DEFAULT_LEN);
            pendLenQ   <= '0;
            pendValidQ <= 1'b0;
            evValidQ   <= 1'b0;
            evChanQ    <= '0;
            evLevelQ   <= 1'b0;
        end else begin
            stateQ     <= stateD;
            idxQ       <= idxD;
            cntQ       <= cntD;
            outQ       <= outD;
            inQ        <= inData;
            filtLenQ   <= filtLenD;
            pendLenQ   <= pendLenD;
            pendValidQ <= pendValidD;
            evValidQ   <= evValidD;
            evChanQ    <= evChanD;
            evLevelQ   <= evLevelD;
        end
    end

    assign outData    = outQ;
    assign eventValid = evValidQ;
    assign eventChan  = evChanQ;
    assign eventLevel = evLevelQ;

endmodule

// File: tb/tb_glitch_filter_scheduler.sv
// Bench for glitch_filter_scheduler with CHANNELS=4, CNT_W=8, DEFAULT_LEN=3.
module tb_glitch_filter_scheduler;

    localparam int NCH = 4;

    logic       clk = 1'b0;
    logic       rstN;
    logic       enable;
    logic [3:0] inData;
    logic [3:0] outData;
    logic       cfgValid;
    logic       cfgReady;
    logic [7:0] cfgLen;
    logic       eventValid;
    logic [1:0] eventChan;
    logic       eventLevel;

    glitch_filter_scheduler #(
        .CHANNELS   (4),
        .CNT_W      (8),
        .DEFAULT_LEN(3)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .enable    (enable),
        .inData    (inData),
        .outData   (outData),
        .cfgValid  (cfgValid),
        .cfgReady  (cfgReady),
        .cfgLen    (cfgLen),
        .eventValid(eventValid),
        .eventChan (eventChan),
        .eventLevel(eventLevel)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode 0 idle, 1 scanning, 2 one-cycle length reload.
    int       mMode;
    int       mPtr;
    int       mRun [NCH];
    bit [3:0] mLevel;
    bit [3:0] mSample;
    int       mLen;
    bit       mPend;
    int       mPendLen;
    bit       mEv;
    int       mEvChan;
    bit       mEvLevel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mMode = 0; mPtr = 0; mLevel = '0; mSample = '0; mLen = 3;
        mPend = 0; mPendLen = 0; mEv = 0; mEvChan = 0; mEvLevel = 0;
        for (int c = 0; c < NCH; c++) mRun[c] = 0;
    endtask

    task automatic modelStep();
        int  i;
        int  eff;
        bit  oldPend;
        bit  xfer;
        if (!rstN) begin
            modelReset();
            return;
        end
        oldPend = mPend;
        xfer    = cfgValid && !mPend;
        mEv     = 0;
        case (mMode)
            0: begin
                if (xfer) mLen = int'(cfgLen);
                if (enable) begin mMode = 1; mPtr = 0; end
            end
            1: begin
                i   = mPtr;
                eff = (mLen == 0) ? 1 : mLen;
                if (mSample[i] == mLevel[i]) begin
                    mRun[i] = 0;
                end else if (mRun[i] + 1 >= eff) begin
                    mLevel[i] = mSample[i];
                    mRun[i]   = 0;
                    mEv = 1; mEvChan = i; mEvLevel = mLevel[i];
                end else if (mRun[i] < 255) begin
                    mRun[i]++;
                end
                if (xfer) begin mPend = 1; mPendLen = int'(cfgLen); end
                if (!enable) begin
                    mMode = 0; mPtr = 0;
                    for (int c = 0; c < NCH; c++) mRun[c] = 0;
                end else if (i == NCH - 1) begin
                    mPtr = 0;
                    if (oldPend) mMode = 2;
                end else begin
                    mPtr++;
                end
            end
            default: begin
                mLen = mPendLen; mPend = 0; mPtr = 0;
                for (int c = 0; c < NCH; c++) mRun[c] = 0;
                mMode = enable ? 1 : 0;
            end
        endcase
        mSample = inData;
    endtask

    task automatic compareModel();
        check("model outData", 32'(outData), 32'(mLevel));
        check("model cfgReady", 32'(cfgReady), 32'(!mPend));
        check("model eventValid", 32'(eventValid), 32'(mEv));
        if (mEv) begin
            check("model eventChan", 32'(eventChan), 32'(mEvChan));
            check("model eventLevel", 32'(eventLevel), 32'(mEvLevel));
        end
    endtask

    // One clock: model and DUT both consume the inputs held across the edge.
    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        compareModel();
    endtask

    task automatic idleInputs();
        enable = 0; inData = '0; cfgValid = 0; cfgLen = '0;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rstN = 0;
        idleInputs();
        modelReset();
        #1;
        check("reset outData", 32'(outData), 32'h0);
        check("reset cfgReady", 32'(cfgReady), 32'h1);
        check("reset eventValid", 32'(eventValid), 32'h0);
        tick();
        tick();
        rstN = 1;
    endtask

    typedef struct {
        logic       en;
        logic [3:0] din;
        logic [3:0] expOut;
        logic       expEv;
        logic [1:0] expChan;
        logic       expLvl;
    } vec_t;

    vec_t tbl [18];

    initial begin
        // Step on channel 2: commit on its third visit (row 12), nothing afterwards.
        for (int r = 0; r < 18; r++) begin
            tbl[r].en      = (r != 0);
            tbl[r].din     = (r == 0) ? 4'b0000 : 4'b0100;
            tbl[r].expOut  = (r >= 12) ? 4'b0100 : 4'b0000;
            tbl[r].expEv   = (r == 12);
            tbl[r].expChan = 2'd2;
            tbl[r].expLvl  = 1'b1;
        end

        rstN = 0;
        idleInputs();
        modelReset();
        doReset();

        for (int r = 0; r < 18; r++) begin
            enable = tbl[r].en;
            inData = tbl[r].din;
            tick();
            check($sformatf("step row%0d outData", r), 32'(outData), 32'(tbl[r].expOut));
            check($sformatf("step row%0d eventValid", r), 32'(eventValid), 32'(tbl[r].expEv));
            if (tbl[r].expEv) begin
                check("step eventChan", 32'(eventChan), 32'(tbl[r].expChan));
                check("step eventLevel", 32'(eventLevel), 32'(tbl[r].expLvl));
            end
        end

        // Glitch: channel 1 high for two visits only.
        doReset();
        for (int t = 1; t <= 20; t++) begin
            enable = 1;
            inData = (t <= 8) ? 4'b0010 : 4'b0000;
            tick();
            check("glitch eventValid", 32'(eventValid), 32'h0);
        end
        check("glitch outData", 32'(outData), 32'h0);

        // Reconfigure to length 1 during a sweep.
        doReset();
        enable = 1;
        tick();
        cfgValid = 1; cfgLen = 8'd1;
        tick();
        cfgValid = 0;
        check("reconfig ready after xfer", 32'(cfgReady), 32'h0);
        for (int t = 3; t <= 5; t++) begin
            tick();
            check("reconfig ready pending", 32'(cfgReady), 32'h0);
        end
        inData = 4'b0001;
        tick();
        check("reconfig ready after reload", 32'(cfgReady), 32'h1);
        check("reconfig no event in reload", 32'(eventValid), 32'h0);
        tick();
        check("reconfig immediate commit", 32'(eventValid), 32'h1);
        check("reconfig commit chan", 32'(eventChan), 32'h0);
        check("reconfig outData", 32'(outData), 32'h1);

        // Enable drop with channel 3 two visits into a transition.
        doReset();
        enable = 1; inData = 4'b1000;
        for (int t = 1; t <= 9; t++) begin
            tick();
            check("drop pre eventValid", 32'(eventValid), 32'h0);
        end
        enable = 0;
        for (int t = 10; t <= 12; t++) begin
            tick();
            check("drop idle outData", 32'(outData), 32'h0);
        end
        enable = 1;
        for (int t = 13; t <= 25; t++) begin
            tick();
            check($sformatf("drop t%0d eventValid", t), 32'(eventValid), 32'(t == 25));
        end
        check("drop commit chan", 32'(eventChan), 32'h3);
        check("drop outData", 32'(outData), 32'h8);

        // Length 0 written in idle behaves as 1.
        doReset();
        cfgValid = 1; cfgLen = 8'd0;
        tick();
        cfgValid = 0;
        check("zero ready", 32'(cfgReady), 32'h1);
        enable = 1; inData = 4'b1111;
        tick();
        for (int t = 3; t <= 6; t++) begin
            if (t == 6) inData = 4'b0000;
            tick();
            check("zero eventValid", 32'(eventValid), 32'h1);
            check("zero eventChan", 32'(eventChan), 32'(t - 3));
            check("zero eventLevel", 32'(eventLevel), 32'h1);
        end
        tick();
        check("zero fall eventValid", 32'(eventValid), 32'h1);
        check("zero fall eventLevel", 32'(eventLevel), 32'h0);

        // Randomized run against the model, with occasional mid-run resets.
        doReset();
        inData = '0;
        for (int n = 0; n < 2000; n++) begin
            enable   = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 3) == 0) inData[$urandom_range(0, 3)] ^= 1'b1;
            cfgValid = ($urandom_range(0, 15) == 0);
            cfgLen   = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 299) == 0) begin
                rstN = 0;
                #1;
                check("midrun reset outData", 32'(outData), 32'h0);
                check("midrun reset cfgReady", 32'(cfgReady), 32'h1);
                check("midrun reset eventValid", 32'(eventValid), 32'h0);
                modelReset();
                tick();
                rstN = 1;
            end else begin
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
